imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
Program loader that writes the instruction memory read by the fetch stage. It receives a byte stream over a valid/ready handshake and checks its framing and checksum. It assembles big-endian 32-bit words and drives the memory write port. It holds the processor core stopped while a load is in progress and after a failed load.

Parameters:
ADDR_W, 5, instruction memory address width.
DEPTH, 32, number of instruction words. Constraints: DEPTH <= 2^ADDR_W and DEPTH <= 255.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous reset, active-high.
start  input  1  single-cycle pulse that begins a load.
byte_valid  input  1  byte_data is valid this cycle.
byte_data  input  8  incoming stream byte.
byte_ready  output  1  loader accepts a byte this cycle.
mem_we  output  1  instruction memory write strobe, one cycle per word.
mem_addr  output  ADDR_W  write word address.
mem_wdata  output  32  write word.
core_hold  output  1  holds the fetch/ALU core stopped.
done  output  1  load completed with a good checksum (sticky).
error  output  1  load failed (sticky).

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. All outputs are registered.
- Reset values: state IDLE; byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, core_hold=0, done=0, error=0. Internal word counter, byte index and checksum are cleared.
- Handshake: a byte is accepted on a rising edge where byte_valid=1 and byte_ready=1. In any other cycle byte_data is ignored. The sender may hold byte_valid low for any number of cycles between bytes.
- Frame format: one length byte N (1..DEPTH), then 4*N data bytes (each word MSB first), then one checksum byte. The checksum byte equals the XOR of all data bytes; the length byte is excluded.
- States and transitions:
  - IDLE: byte_ready=0. start -> LEN.
  - LEN: byte_ready=1, core_hold=1.
    - Accepted byte of 0 or >DEPTH -> ERR.
    - Otherwise store N, clear word counter, byte index and checksum -> DATA.
  - DATA: byte_ready=1, core_hold=1.
    - Each accepted byte shifts into a 32-bit assembly register, left shift by 8, new byte in the low bits. It is also XORed into the running checksum.
    - On the 4th byte of a word: in the next cycle mem_we=1 for exactly one cycle, with mem_addr = word counter and mem_wdata = assembled word. The word counter then increments and the byte index returns to 0.
    - After the Nth word's 4th byte -> CSUM.
    - A write pulse may coincide with acceptance of the next byte. No bytes are dropped and no stall is inserted.
  - CSUM: byte_ready=1, core_hold=1.
    - Accepted byte equal to the running checksum -> DONE.
    - Any other value -> ERR.
  - DONE: byte_ready=0, done=1, core_hold=0. start -> LEN, clearing done.
  - ERR: byte_ready=0, error=1, core_hold=1. start -> LEN, clearing error.
- start is ignored in LEN, DATA and CSUM.
- Address boundary: mem_addr never exceeds N-1 and never wraps. For N=DEPTH the last write is to DEPTH-1.
- mem_addr and mem_wdata hold their last values when mem_we=0.
- Reset mid-load: next state IDLE and mem_we=0 from the reset edge. Words already written stay in memory; the loader does not clear memory. core_hold drops to 0.
- Simultaneous rst and start: rst wins.
- Latency: the write of a word occurs 1 cycle after acceptance of its 4th byte. done or error is asserted 1 cycle after acceptance of the checksum byte.

Test Plan:
1. Good load. Pulse start, then send 0x02, 3C 80 00 03, 00 00 00 22, checksum 0x9D, back-to-back.
   -> mem_we pulses twice: addr 0 = 0x3C800003, addr 1 = 0x00000022.
   -> done=1, error=0, core_hold returns to 0.
2. Same stream with checksum 0x9C.
   -> both writes still occur; error=1, done=0, core_hold stays 1.
   -> a new start plus a good frame gives done=1 and error=0.
3. Length errors.
   -> length byte 0x00 gives error=1 with no mem_we.
   -> after restart, length byte 0x21 (33) gives error=1 with no mem_we.
4. Throttled sender. Repeat test 1 with byte_valid high only every third cycle. Also drive byte_valid=1 with byte 0xFF while in IDLE.
   -> identical writes and done=1; no acceptance and no mem_we while in IDLE.
5. Reset mid-load. Assert rst after 6 data bytes of test 1.
   -> only addr 0 written; all outputs at reset values the next cycle.
   -> a subsequent full load succeeds.
6. Full depth. N=32 with word k = 0xA5000000+k.
   -> 32 writes at addr 0..31 in order; the last is addr 31 = 0xA500001F; no write to addr 0 after it; done=1.

Source files
------------

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Purpose  : Framed, checksummed byte-stream loader for the instruction memory;
//            keeps the core stopped during a load and after a failed one.
// Revision : 1.0  initial release
// ============================================================================
module imem_loader #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_hold,
    output logic              done,
    output logic              error
);

    localparam logic [2:0] c_S_IDLE = 3'd0;
    localparam logic [2:0] c_S_LEN  = 3'd1;
    localparam logic [2:0] c_S_DATA = 3'd2;
    localparam logic [2:0] c_S_CSUM = 3'd3;
    localparam logic [2:0] c_S_DONE = 3'd4;
    localparam logic [2:0] c_S_ERR  = 3'd5;

    localparam logic [7:0] c_DEPTH = 8'(DEPTH);

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;

    logic [7:0]        r_len;
    logic [7:0]        r_word_cnt;
    logic [1:0]        r_byte_idx;
    logic [7:0]        r_csum;
    logic [23:0]       r_asm;

    logic              r_byte_ready;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic              r_core_hold;
    logic              r_done;
    logic              r_error;

    logic              w_ready_nxt;
    logic              w_hold_nxt;
    logic              w_done_nxt;
    logic              w_error_nxt;

    logic              w_accept;
    logic              w_len_bad;
    logic              w_word_end;
    logic              w_last_word;
    logic [ADDR_W-1:0] w_word_addr;

    assign w_accept    = byte_valid & r_byte_ready;
    assign w_len_bad   = (byte_data == 8'd0) || (byte_data > c_DEPTH);
    assign w_word_end  = (r_byte_idx == 2'd3);
    assign w_last_word = (r_word_cnt == (r_len - 8'd1));

    generate
        if (ADDR_W >= 8) begin : g_addr_wide
            assign w_word_addr = ADDR_W'(r_word_cnt);
        end else begin : g_addr_narrow
            assign w_word_addr = r_word_cnt[ADDR_W-1:0];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (start) w_state_nxt = c_S_LEN;
            end
            c_S_LEN: begin
                if (w_accept) w_state_nxt = w_len_bad ? c_S_ERR : c_S_DATA;
            end
            c_S_DATA: begin
                if (w_accept && w_word_end && w_last_word) w_state_nxt = c_S_CSUM;
            end
            c_S_CSUM: begin
                if (w_accept) w_state_nxt = (byte_data == r_csum) ? c_S_DONE : c_S_ERR;
            end
            c_S_DONE, c_S_ERR: begin
                if (start) w_state_nxt = c_S_LEN;
            end
            default: w_state_nxt = c_S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Output decode on the next state so the flags are registered yet aligned
    // with the state they belong to.
    // ------------------------------------------------------------------------
    always_comb begin
        w_ready_nxt = 1'b0;
        w_hold_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_error_nxt = 1'b0;
        case (w_state_nxt)
            c_S_LEN, c_S_DATA, c_S_CSUM: begin
                w_ready_nxt = 1'b1;
                w_hold_nxt  = 1'b1;
            end
            c_S_DONE: w_done_nxt = 1'b1;
            c_S_ERR: begin
                w_hold_nxt  = 1'b1;
                w_error_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte_ready <= 1'b0;
            r_core_hold  <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_byte_ready <= w_ready_nxt;
            r_core_hold  <= w_hold_nxt;
            r_done       <= w_done_nxt;
            r_error      <= w_error_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Datapath: length capture, word assembly, checksum and write port
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len       <= 8'd0;
            r_word_cnt  <= 8'd0;
            r_byte_idx  <= 2'd0;
            r_csum      <= 8'd0;
            r_asm       <= 24'd0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 32'd0;
        end else begin
            r_mem_we <= 1'b0;
            if (w_accept && (r_state == c_S_LEN) && !w_len_bad) begin
                r_len      <= byte_data;
                r_word_cnt <= 8'd0;
                r_byte_idx <= 2'd0;
                r_csum     <= 8'd0;
            end
            if (w_accept && (r_state == c_S_DATA)) begin
                r_asm  <= {r_asm[15:0], byte_data};
                r_csum <= r_csum ^ byte_data;
                if (w_word_end) begin
                    // Write fires the cycle after the 4th byte; the next byte may be accepted meanwhile.
                    r_mem_we    <= 1'b1;
                    r_mem_addr  <= w_word_addr;
                    r_mem_wdata <= {r_asm, byte_data};
                    r_word_cnt  <= r_word_cnt + 8'd1;
                    r_byte_idx  <= 2'd0;
                end else begin
                    r_byte_idx <= r_byte_idx + 2'd1;
                end
            end
        end
    end

    assign byte_ready = r_byte_ready;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign core_hold  = r_core_hold;
    assign done       = r_done;
    assign error      = r_error;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Purpose  : Directed self-checking bench for imem_loader with a write scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_imem_loader;

    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              core_hold;
    logic              done;
    logic              error;

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .core_hold  (core_hold),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          n_chk   = 0;
    int          n_fail  = 0;
    int          neg_cnt = 0;
    int          wcount  = 0;
    logic [31:0] img   [DEPTH];
    logic [31:0] words [DEPTH];
    logic [7:0]  last_csum;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every cycle: a write must appear exactly when the model scheduled one, nowhere else.
    initial begin
        forever begin
            @(negedge clk);
            neg_cnt++;
            if (mem_we === 1'b1) begin
                img[mem_addr] = mem_wdata;
                wcount++;
            end
            if (exp_q.size() > 0 && exp_q[0].due == neg_cnt) begin
                chk("wr_strobe", 32'(mem_we), 32'd1);
                chk("wr_addr", 32'(mem_addr), exp_q[0].addr);
                chk("wr_data", mem_wdata, exp_q[0].data);
                void'(exp_q.pop_front());
            end else begin
                chk("no_wr", 32'(mem_we), 32'd0);
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit push_wr,
                             input logic [31:0] addr, input logic [31:0] data);
        bit ok = 1'b0;
        byte_valid = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
        byte_valid = 1'b1;
        byte_data  = b;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (byte_ready) begin
                @(posedge clk);
                ok = 1'b1;
                if (push_wr) exp_q.push_back('{neg_cnt + 1, addr, data});
            end
        end
        #1 byte_valid = 1'b0;
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL handshake_timeout: byte 0x%02h never accepted", b);
        end
    endtask

    // Sends a whole frame built from words[0..n-1]; stop_after > 0 aborts after that many data bytes.
    task automatic run_frame(input int n, input int gap, input bit bad_csum, input int stop_after);
        logic [7:0] cs = 8'd0;
        logic [7:0] b;
        int         w0 = wcount;
        pulse_start();
        send_byte(8'(n), gap, 1'b0, 32'd0, 32'd0);
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < 4; j++) begin
                b  = words[k][31 - 8*j -: 8];
                cs = cs ^ b;
                send_byte(b, gap, j == 3, 32'(k), words[k]);
                if (stop_after > 0 && (4*k + j + 1) == stop_after) return;
            end
        end
        last_csum = cs;
        send_byte(bad_csum ? (cs ^ 8'h01) : cs, gap, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        chk("frame_done", 32'(done), 32'(!bad_csum));
        chk("frame_error", 32'(error), 32'(bad_csum));
        chk("frame_hold", 32'(core_hold), 32'(bad_csum));
        chk("frame_ready", 32'(byte_ready), 32'd0);
        chk("frame_wcount", 32'(wcount - w0), 32'(n));
    endtask

    task automatic len_err(input logic [7:0] len);
        int w0 = wcount;
        pulse_start();
        send_byte(len, 0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        chk("len_error", 32'(error), 32'd1);
        chk("len_done", 32'(done), 32'd0);
        chk("len_hold", 32'(core_hold), 32'd1);
        chk("len_no_wr", 32'(wcount - w0), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(byte_ready), 32'd0);
        chk({tag, "_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_hold"}, 32'(core_hold), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
    endtask

    task automatic set_small_words();
        words[0] = 32'h3C80_0003;
        words[1] = 32'h0000_0022;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        rst        = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        for (int i = 0; i < DEPTH; i++) img[i] = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("reset");

        // Bytes offered while idle must be ignored.
        @(posedge clk);
        #1;
        byte_valid = 1'b1;
        byte_data  = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_ready", 32'(byte_ready), 32'd0);
            chk("idle_hold", 32'(core_hold), 32'd0);
        end
        @(posedge clk);
        #1 byte_valid = 1'b0;

        // Good load, back-to-back.
        set_small_words();
        run_frame(2, 0, 1'b0, 0);
        chk("t1_csum_model", 32'(last_csum), 32'h9D);
        chk("t1_img0", img[0], 32'h3C80_0003);
        chk("t1_img1", img[1], 32'h0000_0022);

        // Bad checksum, then recovery.
        img[0] = 32'h0;
        img[1] = 32'h0;
        run_frame(2, 0, 1'b1, 0);
        chk("t2_img0", img[0], 32'h3C80_0003);
        chk("t2_img1", img[1], 32'h0000_0022);
        run_frame(2, 0, 1'b0, 0);

        // Length errors.
        len_err(8'h00);
        len_err(8'h21);

        // Throttled sender.
        img[0] = 32'h0;
        img[1] = 32'h0;
        run_frame(2, 2, 1'b0, 0);
        chk("t4_img0", img[0], 32'h3C80_0003);
        chk("t4_img1", img[1], 32'h0000_0022);

        // Reset after 6 data bytes.
        w0 = wcount;
        run_frame(2, 0, 1'b0, 6);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("midrst");
        chk("t5_wcount", 32'(wcount - w0), 32'd1);
        run_frame(2, 0, 1'b0, 0);

        // Full depth.
        for (int k = 0; k < DEPTH; k++) words[k] = 32'hA500_0000 + 32'(k);
        run_frame(DEPTH, 0, 1'b0, 0);
        chk("t6_csum_model", 32'(last_csum), 32'h00);
        chk("t6_img0", img[0], 32'hA500_0000);
        chk("t6_img31", img[31], 32'hA500_001F);

        repeat (5) @(posedge clk);
        #1;
        chk("pending_writes", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
